// File: rtl/tdma_mux_scheduler_pkg.sv
// tdma_mux_pkg: shared types and helpers for the TDMA output-mux scheduler.
//   tdma_state_e : schedule phases, visited in fixed order
//   DOM_D1/DOM_D2: encodings driven on sel
//   cnt_width()  : phase counter width for given slot/scrub lengths
package tdma_mux_pkg;

    typedef enum logic [1:0] {
        SLOT_D1  = 2'd0,
        SCRUB_12 = 2'd1,
        SLOT_D2  = 2'd2,
        SCRUB_21 = 2'd3
    } tdma_state_e;

    localparam logic DOM_D1 = 1'b0;
    localparam logic DOM_D2 = 1'b1;

    // clog2(max(slot_len, scrub_len)), never below 1 bit.
    function automatic int cnt_width(input int slot_len, input int scrub_len);
        int m;
        m = (slot_len > scrub_len) ? slot_len : scrub_len;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tdma_mux_scheduler_if.sv
// tdma_mux_scheduler_if: requester handshakes plus the shared output port.
//   master : requester/consumer side (drives valids and data)
//   slave  : scheduler side (drives readies, sel, out_*, frame_start)
interface tdma_mux_scheduler_if #(
    parameter int WIDTH = 8
);
    logic             d1_valid;
    logic [WIDTH-1:0] d1_data;
    logic             d1_ready;
    logic             d2_valid;
    logic [WIDTH-1:0] d2_data;
    logic             d2_ready;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             frame_start;

    modport master (
        output d1_valid, d1_data, d2_valid, d2_data,
        input  d1_ready, d2_ready, sel, out_valid, out_data, frame_start
    );

    modport slave (
        input  d1_valid, d1_data, d2_valid, d2_data,
        output d1_ready, d2_ready, sel, out_valid, out_data, frame_start
    );
endinterface

// File: rtl/tdma_mux_scheduler_phase_timer.sv
// phase_timer: counts 0..term_i while en_i is high, then wraps to 0.
//   clk, rst   : clock, async active-high reset (count -> 0)
//   en_i       : advance the count this cycle
//   term_i     : terminal count of the current phase
//   cnt_nxt_o  : count value after the coming edge
//   done_o     : high on the terminal cycle of an enabled phase
module phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [CW-1:0] term_i,
    output logic [CW-1:0] cnt_nxt_o,
    output logic          done_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = (cnt_q == term_i) ? '0 : cnt_q + 1'b1;
    end

    assign done_o    = en_i && (cnt_q == term_i);
    assign cnt_nxt_o = cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tdma_mux_scheduler.sv
// tdma_mux_scheduler: fixed-schedule time-division owner of the two-domain
// output mux. The schedule (and hence sel) depends only on the phase counter,
// never on requester traffic. Each slot is followed by a scrub window in which
// the shared output register is held at zero.
//   clk, rst : clock, async active-high reset
//   bus      : slave modport - d1/d2 valid/data/ready, sel, out_valid,
//              out_data, frame_start
module tdma_mux_scheduler
    import tdma_mux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SLOT_LEN  = 4,
    parameter int SCRUB_LEN = 1
) (
    input  logic                clk,
    input  logic                rst,
    tdma_mux_scheduler_if.slave bus
);
    localparam int CW = cnt_width(SLOT_LEN, SCRUB_LEN);
    localparam logic [CW-1:0] SLOT_TERM  = CW'(SLOT_LEN - 1);
    localparam logic [CW-1:0] SCRUB_TERM = CW'(SCRUB_LEN - 1);
    localparam logic [CW-1:0] RDY_LAST   = CW'(SLOT_LEN - 2);

    tdma_state_e      state_q, state_d;
    logic             arm_q;
    logic [CW-1:0]    term, cnt_nxt;
    logic             done;
    logic             sel_q, d1_ready_q, d2_ready_q, frame_start_q, out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             acc1, acc2;

    // arm_q holds the timer for the first edge after reset so that the
    // registered outputs can be loaded with the SLOT_D1/count-0 decode;
    // that edge opens cycle 0 of the schedule.
    phase_timer #(.CW(CW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en_i      (arm_q),
        .term_i    (term),
        .cnt_nxt_o (cnt_nxt),
        .done_o    (done)
    );

    assign term = (state_q == SLOT_D1 || state_q == SLOT_D2) ? SLOT_TERM : SCRUB_TERM;

    always_comb begin
        state_d = state_q;
        if (done) begin
            case (state_q)
                SLOT_D1:  state_d = SCRUB_12;
                SCRUB_12: state_d = SLOT_D2;
                SLOT_D2:  state_d = SCRUB_21;
                default:  state_d = SLOT_D1;
            endcase
        end
    end

    // Ready is registered, so it already reflects the current phase; ready is
    // never high outside the owner's slot, so only one accept can occur.
    assign acc1 = bus.d1_valid && d1_ready_q;
    assign acc2 = bus.d2_valid && d2_ready_q;

    // State plus registered outputs. Outputs are decoded from the next
    // state/count so they line up with the phase they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SLOT_D1;
            arm_q         <= 1'b0;
            sel_q         <= DOM_D1;
            d1_ready_q    <= 1'b0;
            d2_ready_q    <= 1'b0;
            frame_start_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            arm_q         <= 1'b1;
            state_q       <= state_d;
            sel_q         <= (state_d == SLOT_D2 || state_d == SCRUB_21) ? DOM_D2 : DOM_D1;
            // Last slot cycle has ready low, so nothing lands in the scrub.
            d1_ready_q    <= (state_d == SLOT_D1) && (cnt_nxt <= RDY_LAST);
            d2_ready_q    <= (state_d == SLOT_D2) && (cnt_nxt <= RDY_LAST);
            frame_start_q <= (state_d == SLOT_D1) && (cnt_nxt == '0);
            out_valid_q   <= acc1 || acc2;
            out_data_q    <= acc1 ? bus.d1_data : (acc2 ? bus.d2_data : '0);
        end
    end

    assign bus.sel         = sel_q;
    assign bus.d1_ready    = d1_ready_q;
    assign bus.d2_ready    = d2_ready_q;
    assign bus.frame_start = frame_start_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
endmodule

// File: tb/tb_tdma_mux_scheduler.sv
// Scoreboard bench for tdma_mux_scheduler (WIDTH=8, SLOT_LEN=4, SCRUB_LEN=1).
// Tests push hand-computed beats {data, sel, cycle}; a negedge monitor pops
// one whenever out_valid is high and also checks the fixed schedule
// (sel, readies, frame_start, scrub zeroing) against the cycle count.
module tb_tdma_mux_scheduler;
    localparam int W  = 8;
    localparam int SL = 4;
    localparam int SC = 1;
    localparam int FR = 2 * (SL + SC);

    typedef struct {
        logic [W-1:0] data;
        logic         sel;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = -1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    tdma_mux_scheduler_if #(.WIDTH(W)) bus ();

    tdma_mux_scheduler #(.WIDTH(W), .SLOT_LEN(SL), .SCRUB_LEN(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the cycle opened by the first edge after reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= -1;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic s, input int c);
        exp_t e;
        e.data = d;
        e.sel  = s;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " sel"},         32'(bus.sel),         32'd0);
        chk({tag, " d1_ready"},    32'(bus.d1_ready),    32'd0);
        chk({tag, " d2_ready"},    32'(bus.d2_ready),    32'd0);
        chk({tag, " out_valid"},   32'(bus.out_valid),   32'd0);
        chk({tag, " out_data"},    32'(bus.out_data),    32'd0);
        chk({tag, " frame_start"}, 32'(bus.frame_start), 32'd0);
    endtask

    // Monitor: schedule model plus scoreboard pop.
    always @(negedge clk) begin : mon
        int   ph;
        logic esel, efs, er1, er2, scrub;
        exp_t e;
        if (!rst && cyc >= 0) begin
            ph    = cyc % FR;
            esel  = (ph >= SL + SC);
            efs   = (ph == 0);
            er1   = (ph <= SL - 2);
            er2   = (ph >= SL + SC) && (ph <= 2 * SL + SC - 2);
            scrub = (ph >= SL && ph < SL + SC) || (ph >= 2 * SL + SC);
            chk("sel",         32'(bus.sel),         32'(esel));
            chk("frame_start", 32'(bus.frame_start), 32'(efs));
            chk("d1_ready",    32'(bus.d1_ready),    32'(er1));
            chk("d2_ready",    32'(bus.d2_ready),    32'(er2));
            if (scrub) chk("scrub out_valid", 32'(bus.out_valid), 32'd0);
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected beat: got data %0h at cycle %0d, expected no beat",
                             bus.out_data, cyc);
                end else begin
                    e = q.pop_front();
                    chk("beat data",  32'(bus.out_data), 32'(e.data));
                    chk("beat sel",   32'(bus.sel),      32'(e.sel));
                    chk("beat cycle", 32'(cyc),          32'(e.cyc));
                end
            end else begin
                chk("idle out_data", 32'(bus.out_data), 32'd0);
            end
        end
    end

    // Assert reset, check reset outputs, release; returns at cycle 0 negedge.
    task automatic do_reset();
        rst          = 1'b1;
        bus.d1_valid = 1'b0;
        bus.d2_valid = 1'b0;
        bus.d1_data  = '0;
        bus.d2_data  = '0;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Requester: present a beat, hold it until ready, drop valid after accept.
    // Called and returns at a negedge.
    task automatic send(input int dom, input logic [W-1:0] d);
        int n;
        n = 0;
        if (dom == 1) begin bus.d1_valid = 1'b1; bus.d1_data = d; end
        else          begin bus.d2_valid = 1'b1; bus.d2_data = d; end
        while (!((dom == 1) ? bus.d1_ready : bus.d2_ready)) begin
            @(negedge clk);
            n++;
            if (n > 4 * FR) begin
                checks++;
                errors++;
                $display("FAIL handshake timeout: domain %0d data %0h not accepted, expected within %0d cycles",
                         dom, d, 4 * FR);
                break;
            end
        end
        @(negedge clk);
        if (dom == 1) bus.d1_valid = 1'b0;
        else          bus.d2_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int g;
        g = 0;
        while (cyc < n && g < 1000) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic chk_drained(input string name);
        chk(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle frames: schedule only, no beats may appear.
        do_reset();
        wait_cyc(20);
        chk_drained("idle drained");

        // D1 streaming: fourth beat misses the slot end and waits a frame.
        do_reset();
        push(8'h11, 1'b0, 1);
        push(8'h22, 1'b0, 2);
        push(8'h33, 1'b0, 3);
        push(8'h44, 1'b0, 11);
        send(1, 8'h11);
        send(1, 8'h22);
        send(1, 8'h33);
        send(1, 8'h44);
        wait_cyc(13);
        chk_drained("d1 stream drained");

        // Cross-domain isolation: D2 beat offered during D1 slot waits for SLOT_D2.
        do_reset();
        push(8'hAA, 1'b1, 6);
        send(2, 8'hAA);
        wait_cyc(12);
        chk_drained("isolation drained");

        // Both domains saturated for three frames: three beats each per slot.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 3; k++) push(8'(8'h10 + 3 * f + k), 1'b0, f * FR + 1 + k);
            for (int k = 0; k < 3; k++) push(8'(8'h80 + 3 * f + k), 1'b1, f * FR + 6 + k);
        end
        fork
            begin
                for (int i = 0; i < 9; i++) send(1, 8'(8'h10 + i));
            end
            begin
                for (int j = 0; j < 9; j++) send(2, 8'(8'h80 + j));
            end
        join
        wait_cyc(31);
        chk_drained("saturated drained");

        // Mid-slot reset while 0x5C sits on the output in D2 slot cycle 2.
        do_reset();
        wait_cyc(6);
        push(8'h5C, 1'b1, 7);
        send(2, 8'h5C);
        #2 rst = 1'b1;
        #1 chk_reset_outs("mid-slot reset");
        chk_drained("mid-slot beat seen");
        do_reset();
        wait_cyc(12);
        chk_drained("post reset drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdma_mux_scheduler.md
# tdma_mux_scheduler

Time-division scheduler that shares the two-domain output mux between requester D1 and requester D2. Grant slots follow a fixed, data-independent schedule, so the public select (label L) never depends on either domain's traffic. Each slot is followed by a scrub window that clears the shared output register before the channel changes owner. The block sits directly in front of the domain-selected output port and drives its select.

## Interface
Parameters:
- WIDTH, 8, data width of each requester and of the output
- SLOT_LEN, 4, cycles per domain slot; must be ≥ 2
- SCRUB_LEN, 1, scrub cycles after each slot; must be ≥ 1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- d1_valid  in  1  D1 has a beat (label D1)
- d1_data  in  WIDTH  D1 beat (label D1)
- d1_ready  out  1  D1 beat accepted this cycle when d1_valid is also high
- d2_valid  in  1  D2 has a beat (label D2)
- d2_data  in  WIDTH  D2 beat (label D2)
- d2_ready  out  1  D2 beat accepted this cycle when d2_valid is also high
- sel  out  1  owning domain (0 = D1, 1 = D2), label L
- out_valid  out  1  out_data holds an accepted beat (label Domain sel)
- out_data  out  WIDTH  registered beat (label Domain sel)
- frame_start  out  1  one-cycle pulse on cycle 0 of the SLOT_D1 phase

## Operation
- States: SLOT_D1 → SCRUB_12 → SLOT_D2 → SCRUB_21 → SLOT_D1.
- A phase counter counts 0..SLOT_LEN-1 in slot states and 0..SCRUB_LEN-1 in scrub states. The state advances when the counter reaches its terminal value; the counter then returns to 0.
- The transitions depend only on the counter. valid, ready and data never influence state, counter or sel.
- sel:
  - 0 in SLOT_D1 and SCRUB_12.
  - 1 in SLOT_D2 and SCRUB_21.
- dN_ready is high in SLOT_DN for counter values 0..SLOT_LEN-2 and low at all other times. It does not depend on dN_valid. The other domain's ready is always low during SLOT_DN.
- Accepted beat (dN_valid & dN_ready): out_data takes dN_data and out_valid goes to 1 on the next edge.
- Slot cycle with no accepted beat: out_valid goes to 0 and out_data to 0.
- Scrub cycles: out_valid is 0 and out_data is 0. No beat can be in flight, because ready is low on the last slot cycle.
- frame_start = (state == SLOT_D1) & (counter == 0).

## Timing
- Reset values: state SLOT_D1, counter 0, sel 0, d1_ready 0, d2_ready 0, out_valid 0, out_data 0, frame_start 0.
- First cycle after rst deasserts: SLOT_D1 counter 0. frame_start = 1 and d1_ready = 1 in that cycle.
- Latency: a beat accepted at slot cycle k appears on out_data/out_valid at slot cycle k+1, under the same sel.
- Per slot: at most SLOT_LEN-1 beats per domain.
- Frame period: 2·(SLOT_LEN+SCRUB_LEN) cycles.
- Counter width: clog2(max(SLOT_LEN, SCRUB_LEN)). Wrap-around happens exactly at the terminal value, with no overflow.
- Valid held across a slot end: ready drops and the beat is not consumed. It waits for the next own slot, and the requester must hold the data stable.
- rst asserted mid-slot or mid-scrub: all outputs go to their reset values immediately (asynchronous). The in-flight out_data is discarded and not replayed.
- dN_valid high in the other domain's slot: ignored, no effect on any output.

## Structure
- Package tdma_mux_pkg holds:
  - the state enum (SLOT_D1, SCRUB_12, SLOT_D2, SCRUB_21);
  - the sel encodings DOM_D1 = 0 and DOM_D2 = 1;
  - a function computing the counter width.
- Sub-module phase_timer: parameterised counter taking the terminal value and producing a done pulse. It is instantiated once; the FSM selects SLOT_LEN-1 or SCRUB_LEN-1 as the terminal value.
- The output register and handshake logic live in the top module. The security labels on the ports are exactly as listed under Interface.

## Test plan
(WIDTH=8, SLOT_LEN=4, SCRUB_LEN=1)
- Idle frames: no valids for 20 cycles after reset.
  - sel = 0,0,0,0,0,1,1,1,1,1 repeating.
  - frame_start at cycles 0 and 10.
  - out_valid is never 1.
- D1 streaming: d1_valid held 1 with data 0x11, 0x22, 0x33, 0x44.
  - 0x11, 0x22, 0x33 are out at cycles 1–3 with sel = 0.
  - Cycle 4 (scrub): out_data = 0.
  - 0x44 is accepted only at cycle 10 and is out at cycle 11.
- Cross-domain isolation: d2_valid = 1 with 0xAA during cycles 0–4.
  - d2_ready stays 0.
  - 0xAA is out at cycle 6 with sel = 1.
  - sel never changes in response to either valid.
- Both domains saturated for 3 frames.
  - Exactly 3 beats per domain per frame.
  - out_data = 0 in every scrub cycle.
- Mid-slot reset: assert rst at D2 slot cycle 2 while out_valid = 1 with 0x5C.
  - All outputs go to reset values in the same cycle.
  - After release, the sequence restarts at SLOT_D1 counter 0.
  - 0x5C never reappears.
